// File: rtl/data_ram_pkg.sv
// Shared size encodings and access-decode helpers for the byte-banked data RAM.
package data_ram_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam int unsigned MAX_NB = 8;

   // Byte-lane enables for an access of 2**size bytes starting at lane 'offset'.
   function automatic logic [MAX_NB-1:0] lane_mask(input logic [1:0] size,
                                                   input logic [2:0] offset);
      logic [MAX_NB-1:0] base;
      case (size)
         SZ_B:    base = 8'h01;
         SZ_H:    base = 8'h03;
         SZ_W:    base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return base << offset;
   endfunction

   // Legal iff the access fits the word and is naturally aligned.
   function automatic logic is_legal(input logic [1:0] size, input logic [2:0] offset,
                                     input int unsigned nb);
      logic [3:0] span;
      span = 4'd1 << size;
      return (32'(span) <= nb) && (({1'b0, offset} & (span - 4'd1)) == 4'd0);
   endfunction

endpackage

// File: rtl/data_ram_bank.sv
// One byte lane of the data RAM: synchronous write, registered synchronous read.
module data_ram_bank #(
   parameter int unsigned DEPTH = 4096,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic          re_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rdata_o
);

   logic [7:0] mem_q [DEPTH];
   logic [7:0] rdata_q;

   // Read returns the pre-write contents; the top handles same-word forwarding.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram.sv
// Byte-banked data RAM with size decode, lane steering, load extension,
// misalignment errors and write-first forwarding on same-word read/write.
module data_ram
   import data_ram_pkg::*;
#(
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 4096
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_req_i,
   input  logic [31:0]   wr_addr_i,
   input  logic [1:0]    wr_size_i,
   input  logic [DW-1:0] wr_data_i,
   input  logic          rd_req_i,
   input  logic [31:0]   rd_addr_i,
   input  logic [1:0]    rd_size_i,
   input  logic          rd_unsigned_i,
   output logic          rd_valid_o,
   output logic [DW-1:0] rd_data_o,
   output logic          wr_err_o,
   output logic          rd_err_o
);

   localparam int unsigned NB = DW / 8;
   localparam int unsigned LB = $clog2(NB);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW-1:0]     wr_idx, rd_idx;
   logic [LB-1:0]     wr_off, rd_off;
   logic              wr_ok, rd_ok, rd_fire;
   logic [MAX_NB-1:0] wr_mask_full;
   logic [NB-1:0]     wr_be, fwd_mask;
   logic [DW-1:0]     wr_rep;

   assign wr_idx = wr_addr_i[LB+AW-1:LB];
   assign wr_off = wr_addr_i[LB-1:0];
   assign rd_idx = rd_addr_i[LB+AW-1:LB];
   assign rd_off = rd_addr_i[LB-1:0];

   assign wr_ok        = is_legal(wr_size_i, 3'(wr_off), NB);
   assign rd_ok        = is_legal(rd_size_i, 3'(rd_off), NB);
   assign rd_fire      = rd_req_i & rd_ok;
   assign wr_mask_full = lane_mask(wr_size_i, 3'(wr_off));
   assign wr_be        = wr_mask_full[NB-1:0] & {NB{wr_req_i & wr_ok}};
   assign fwd_mask     = (wr_idx == rd_idx) ? wr_be : '0;

   // Replicate the right-aligned store data so every enabled lane sees its byte.
   always_comb begin
      wr_rep = '0;
      for (int i = 0; i < NB; i++) begin
         case (wr_size_i)
            SZ_B:    wr_rep[8*i +: 8] = wr_data_i[7:0];
            SZ_H:    wr_rep[8*i +: 8] = wr_data_i[8*(i % 2) +: 8];
            SZ_W:    wr_rep[8*i +: 8] = wr_data_i[8*(i % 4) +: 8];
            default: wr_rep[8*i +: 8] = wr_data_i[8*i +: 8];
         endcase
      end
   end

   logic [DW-1:0] bank_rdata;

   for (genvar g = 0; g < NB; g++) begin : g_bank
      data_ram_bank #(
         .DEPTH (DEPTH),
         .AW    (AW)
      ) u_bank (
         .clk_i   (clk),
         .we_i    (wr_be[g]),
         .waddr_i (wr_idx),
         .wdata_i (wr_rep[8*g +: 8]),
         .re_i    (rd_fire),
         .raddr_i (rd_idx),
         .rdata_o (bank_rdata[8*g +: 8])
      );
   end

   logic          valid_q, rd_err_q, wr_err_q, uns_q;
   logic [LB-1:0] off_q;
   logic [1:0]    size_q;
   logic [NB-1:0] fwd_mask_q;
   logic [DW-1:0] fwd_data_q, hold_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q    <= 1'b0;
         rd_err_q   <= 1'b0;
         wr_err_q   <= 1'b0;
         uns_q      <= 1'b0;
         off_q      <= '0;
         size_q     <= '0;
         fwd_mask_q <= '0;
         fwd_data_q <= '0;
         hold_q     <= '0;
      end else begin
         valid_q  <= rd_req_i;
         rd_err_q <= rd_req_i & ~rd_ok;
         wr_err_q <= wr_req_i & ~wr_ok;
         hold_q   <= rd_data_o;
         if (rd_fire) begin
            off_q      <= rd_off;
            size_q     <= rd_size_i;
            uns_q      <= rd_unsigned_i;
            fwd_mask_q <= fwd_mask;
            fwd_data_q <= wr_rep;
         end
      end
   end

   logic [DW-1:0] merged, shifted, keep, msb_mask, load_data;
   logic [6:0]    ext_bits;
   logic          sign;

   always_comb begin
      merged = '0;
      for (int i = 0; i < NB; i++) begin
         merged[8*i +: 8] = fwd_mask_q[i] ? fwd_data_q[8*i +: 8] : bank_rdata[8*i +: 8];
      end
      shifted  = merged >> {off_q, 3'b000};
      ext_bits = 7'd8 << size_q;
      if (32'(ext_bits) >= DW) keep = '1;
      else                     keep = (DW'(1) << ext_bits) - DW'(1);
      msb_mask  = keep & ~(keep >> 1);
      sign      = ~uns_q & (|(shifted & msb_mask));
      load_data = rd_err_q ? '0 : ((shifted & keep) | ({DW{sign}} & ~keep));
   end

   assign rd_data_o  = valid_q ? load_data : hold_q;
   assign rd_valid_o = valid_q;
   assign rd_err_o   = rd_err_q;
   assign wr_err_o   = wr_err_q;

   logic unused_sink;
   assign unused_sink = ^{wr_addr_i[31:LB+AW], rd_addr_i[31:LB+AW], wr_mask_full};

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram: byte-array reference model plus directed literal checks.
module tb_data_ram;

   localparam int unsigned DW    = 32;
   localparam int unsigned DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_req_i = 1'b0, rd_req_i = 1'b0, rd_unsigned_i = 1'b0;
   logic [31:0]   wr_addr_i = '0, rd_addr_i = '0;
   logic [1:0]    wr_size_i = '0, rd_size_i = '0;
   logic [DW-1:0] wr_data_i = '0;
   logic          rd_valid_o, wr_err_o, rd_err_o;
   logic [DW-1:0] rd_data_o;

   always #5 clk = ~clk;

   data_ram #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .wr_req_i      (wr_req_i),
      .wr_addr_i     (wr_addr_i),
      .wr_size_i     (wr_size_i),
      .wr_data_i     (wr_data_i),
      .rd_req_i      (rd_req_i),
      .rd_addr_i     (rd_addr_i),
      .rd_size_i     (rd_size_i),
      .rd_unsigned_i (rd_unsigned_i),
      .rd_valid_o    (rd_valid_o),
      .rd_data_o     (rd_data_o),
      .wr_err_o      (wr_err_o),
      .rd_err_o      (rd_err_o)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit check_en = 1'b0;

   logic [7:0]  mem [64];
   logic        exp_valid = 1'b0, exp_rerr = 1'b0, exp_werr = 1'b0;
   logic [31:0] exp_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   function automatic bit legal(input logic [31:0] a, input logic [1:0] s);
      int span;
      span = 1 << s;
      return (span <= 4) && ((a % span) == 0);
   endfunction

   // Reference model: flat byte memory, store applied before the load (write-first).
   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            exp_valid = 1'b0;
            exp_rerr  = 1'b0;
            exp_werr  = 1'b0;
            exp_data  = '0;
         end else begin : model_step
            int          span;
            logic [31:0] v;
            exp_werr = 1'b0;
            if (wr_req_i) begin
               if (legal(wr_addr_i, wr_size_i)) begin
                  for (int k = 0; k < (1 << wr_size_i); k++)
                     mem[wr_addr_i[5:0] + 6'(k)] = wr_data_i[8*k +: 8];
               end else begin
                  exp_werr = 1'b1;
               end
            end
            exp_valid = rd_req_i;
            exp_rerr  = 1'b0;
            if (rd_req_i) begin
               if (!legal(rd_addr_i, rd_size_i)) begin
                  exp_rerr = 1'b1;
                  exp_data = '0;
               end else begin
                  span = 1 << rd_size_i;
                  v    = '0;
                  for (int k = 0; k < span; k++) v[8*k +: 8] = mem[rd_addr_i[5:0] + 6'(k)];
                  if (!rd_unsigned_i)
                     for (int b = 8 * span; b < 32; b++) v[b] = v[8*span-1];
                  exp_data = v;
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (check_en) begin
            chk("rd_valid_o", 32'(rd_valid_o), 32'(exp_valid));
            chk("rd_err_o",   32'(rd_err_o),   32'(exp_rerr));
            chk("wr_err_o",   32'(wr_err_o),   32'(exp_werr));
            chk("rd_data_o",  rd_data_o,       exp_data);
         end
      end
   end

   task automatic cyc(input bit wr, input logic [31:0] wa, input logic [1:0] ws,
                      input logic [31:0] wd, input bit rd, input logic [31:0] ra,
                      input logic [1:0] rs, input bit un);
      wr_req_i      = wr;
      wr_addr_i     = wa;
      wr_size_i     = ws;
      wr_data_i     = wd;
      rd_req_i      = rd;
      rd_addr_i     = ra;
      rd_size_i     = rs;
      rd_unsigned_i = un;
      @(posedge clk);
      #1;
      wr_req_i = 1'b0;
      rd_req_i = 1'b0;
   endtask

   task automatic sw(input logic [31:0] a, input logic [31:0] d);
      cyc(1'b1, a, 2'd2, d, 1'b0, 32'h0, 2'd0, 1'b0);
   endtask

   task automatic ld(input logic [31:0] a, input logic [1:0] s, input bit u);
      cyc(1'b0, 32'h0, 2'd0, 32'h0, 1'b1, a, s, u);
   endtask

   task automatic idle();
      cyc(1'b0, 32'h0, 2'd0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0);
   endtask

   initial begin
      logic [31:0] wa, ra, wd;
      logic [1:0]  ws, rs;
      rst = 1'b1;
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      check_en = 1'b1;
      chk("reset rd_valid", 32'(rd_valid_o), 32'h0);
      chk("reset rd_data",  rd_data_o,       32'h0);
      chk("reset wr_err",   32'(wr_err_o),   32'h0);

      for (int i = 0; i < 16; i++) sw(32'(4 * i), $urandom);

      sw(32'h8, 32'h8765_4321);
      ld(32'h8, 2'd2, 1'b0);
      chk("LW 0x8",  rd_data_o, 32'h8765_4321);
      ld(32'hB, 2'd0, 1'b0);
      chk("LB 0xB",  rd_data_o, 32'hFFFF_FF87);
      ld(32'hB, 2'd0, 1'b1);
      chk("LBU 0xB", rd_data_o, 32'h0000_0087);
      ld(32'hA, 2'd1, 1'b0);
      chk("LH 0xA",  rd_data_o, 32'hFFFF_8765);
      idle();
      chk("hold data",  rd_data_o,         32'hFFFF_8765);
      chk("hold valid", 32'(rd_valid_o),   32'h0);

      sw(32'h8, 32'h1122_3344);
      cyc(1'b1, 32'h9, 2'd0, 32'h0000_00AA, 1'b0, 32'h0, 2'd0, 1'b0);
      ld(32'h8, 2'd2, 1'b0);
      chk("SB merge", rd_data_o, 32'h1122_AA44);

      sw(32'h4, 32'h0102_0304);
      cyc(1'b1, 32'h4, 2'd1, 32'h0000_BEEF, 1'b1, 32'h4, 2'd2, 1'b0);
      chk("fwd LW", rd_data_o, 32'h0102_BEEF);

      cyc(1'b1, 32'h6, 2'd2, 32'hDEAD_BEEF, 1'b0, 32'h0, 2'd0, 1'b0);
      chk("misaligned SW err", 32'(wr_err_o), 32'h1);
      idle();
      chk("wr_err pulse", 32'(wr_err_o), 32'h0);
      ld(32'h4, 2'd2, 1'b0);
      chk("mem unchanged", rd_data_o, 32'h0102_BEEF);
      ld(32'h3, 2'd1, 1'b0);
      chk("LH 0x3 valid", 32'(rd_valid_o), 32'h1);
      chk("LH 0x3 err",   32'(rd_err_o),   32'h1);
      chk("LH 0x3 data",  rd_data_o,       32'h0);
      ld(32'h0, 2'd3, 1'b1);
      chk("LD err", 32'(rd_err_o), 32'h1);
      cyc(1'b1, 32'h0, 2'd3, 32'h1234_5678, 1'b0, 32'h0, 2'd0, 1'b0);
      chk("SD err", 32'(wr_err_o), 32'h1);

      sw(32'h40, 32'hCAFE_F00D);
      ld(32'h0, 2'd2, 1'b0);
      chk("wrap LW", rd_data_o, 32'hCAFE_F00D);

      for (int i = 0; i < 4; i++) begin
         ld(32'(4 * i), 2'd2, 1'b0);
         chk("b2b valid", 32'(rd_valid_o), 32'h1);
      end

      rd_req_i  = 1'b1;
      rd_addr_i = 32'h8;
      rd_size_i = 2'd2;
      @(posedge clk);
      #1;
      rd_req_i = 1'b0;
      chk("pre-reset valid", 32'(rd_valid_o), 32'h1);
      rst = 1'b0;
      #1;
      chk("reset valid drop", 32'(rd_valid_o), 32'h0);
      chk("reset data clear", rd_data_o,       32'h0);
      @(posedge clk);
      #1 rst = 1'b1;
      idle();
      chk("no stale valid", 32'(rd_valid_o), 32'h0);

      repeat (2000) begin
         ws = 2'($urandom_range(0, 3));
         rs = 2'($urandom_range(0, 3));
         wa = $urandom;
         ra = $urandom;
         wd = $urandom;
         if ($urandom_range(0, 3) == 0) ra = {wa[31:2], ra[1:0]};
         if ($urandom_range(0, 4) != 0) wa = wa & ~((32'd1 << ws) - 32'd1);
         if ($urandom_range(0, 4) != 0) ra = ra & ~((32'd1 << rs) - 32'd1);
         cyc(1'($urandom_range(0, 1)), wa, ws, wd, 1'($urandom_range(0, 1)), ra, rs,
             1'($urandom_range(0, 1)));
      end
      idle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
